// File: rtl/rs_pulse_ctrl.sv
// Upstream pulse generator for a NOR RS latch: synchronises and debounces two raw
// requests, turns debounced rising edges into guarded, non-overlapping fixed-width pulses.
`timescale 1ns/1ps
module rs_pulse_ctrl #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned PULSE_W  = 3,
    parameter int unsigned GUARD    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic reset_req,
    output logic set_out,
    output logic reset_out,
    output logic busy,
    output logic q_model
);

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);
    localparam logic [7:0] PW_LAST = 8'(PULSE_W - 1);
    localparam logic [7:0] GD_LAST = 8'(GUARD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SET_P,
        ST_RST_P,
        ST_GUARD
    } state_t;

    // Bit 0 carries the set channel, bit 1 the reset channel.
    logic [1:0]      r_meta;
    logic [1:0]      r_sync;
    logic [1:0]      r_db;
    logic [1:0]      r_db_d;
    logic [1:0]      r_pend;
    logic [1:0][7:0] r_db_cnt;
    logic [1:0]      w_rise;
    logic [1:0]      w_grant;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_cnt;
    logic            w_last_pulse;
    logic            w_last_guard;
    logic            r_q;

    logic            w_set_d;
    logic            w_rst_d;
    logic            w_busy_d;
    logic            r_set_out;
    logic            r_rst_out;
    logic            r_busy;
    logic            r_q_model;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= {reset_req, set_req};
            r_sync <= r_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db     <= '0;
            r_db_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_sync[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_sync[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign w_rise     = r_db & ~r_db_d;
    assign w_grant[1] = (r_state == ST_IDLE) && r_pend[1];
    assign w_grant[0] = (r_state == ST_IDLE) && r_pend[0] && !r_pend[1];

    // A fresh rise on the cycle its old request is granted must stay pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_d <= '0;
            r_pend <= '0;
        end else begin
            r_db_d <= r_db;
            r_pend <= w_rise | (r_pend & ~w_grant);
        end
    end

    assign w_last_pulse = (r_cnt == PW_LAST);
    assign w_last_guard = (r_cnt == GD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_pend[1]) begin
                    w_state_nxt = ST_RST_P;
                end else if (r_pend[0]) begin
                    w_state_nxt = ST_SET_P;
                end
            end
            ST_SET_P, ST_RST_P: begin
                if (w_last_pulse) begin
                    w_state_nxt = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (w_last_guard) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_set_d  = (r_state == ST_SET_P);
        w_rst_d  = (r_state == ST_RST_P);
        w_busy_d = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (r_state != ST_IDLE) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (w_last_pulse && (r_state == ST_SET_P)) begin
            r_q <= 1'b1;
        end else if (w_last_pulse && (r_state == ST_RST_P)) begin
            r_q <= 1'b0;
        end
    end

    // Output flops trail the state register by one cycle; this stage is part of
    // the DEBOUNCE+4 request-to-pulse latency, and q_model trails with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_set_out <= 1'b0;
            r_rst_out <= 1'b0;
            r_busy    <= 1'b0;
            r_q_model <= 1'b0;
        end else begin
            r_set_out <= w_set_d;
            r_rst_out <= w_rst_d;
            r_busy    <= w_busy_d;
            r_q_model <= r_q;
        end
    end

    assign set_out   = r_set_out;
    assign reset_out = r_rst_out;
    assign busy      = r_busy;
    assign q_model   = r_q_model;

endmodule
